// File: rtl/jtcontra_gfx_slot_if.sv
// Graphics ROM fetch bus: two layer-engine request ports plus the single SDRAM read port.
// The slave modport is the responder/arbiter side; the master modport drives requests and SDRAM replies.
interface jtcontra_gfx_slot_if;
  logic        gfx1_cs;
  logic [17:0] gfx1_addr;
  logic [15:0] gfx1_data;
  logic        gfx1_ok;
  logic        gfx2_cs;
  logic [17:0] gfx2_addr;
  logic [15:0] gfx2_data;
  logic        gfx2_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        sdram_rdy;
  logic [15:0] sdram_din;

  modport slave (
    input  gfx1_cs, gfx1_addr, gfx2_cs, gfx2_addr, sdram_ack, sdram_rdy, sdram_din,
    output gfx1_data, gfx1_ok, gfx2_data, gfx2_ok, sdram_req, sdram_addr
  );

  modport master (
    output gfx1_cs, gfx1_addr, gfx2_cs, gfx2_addr, sdram_ack, sdram_rdy, sdram_din,
    input  gfx1_data, gfx1_ok, gfx2_data, gfx2_ok, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtcontra_gfx_slot.sv
// Two-requester gfx ROM responder with a one-word cache per slot; hits answer in the same cycle,
// misses take 3 cycles plus SDRAM latency; sdram_req holds until ack. Option: JTCONTRA_SLOT_STATS_EN (fill counters).
module jtcontra_gfx_slot #(
  parameter logic [21:0] GFX1_OFFSET = 22'h0,
  parameter logic [21:0] GFX2_OFFSET = 22'h40000
) (
  input logic                clk,
  input logic                rstn,
  jtcontra_gfx_slot_if.slave bus
`ifdef JTCONTRA_SLOT_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [15:0]        stat_miss1,
  output logic [15:0]        stat_miss2
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

  state_t      state, state_nxt;
  logic        sel, sel_nxt;          // 0 = gfx1, 1 = gfx2
  logic        last2;                 // last served slot was gfx2
  logic [17:0] req_addr, req_addr_nxt;
  logic        req_q, req_nxt;
  logic [21:0] addr_q, addr_nxt;
  logic        fill;

  logic        valid1, valid2;
  logic [17:0] tag1, tag2;
  logic [15:0] word1, word2;

  logic hit1, hit2, miss1, miss2;

  assign hit1  = valid1 && (bus.gfx1_addr == tag1);
  assign hit2  = valid2 && (bus.gfx2_addr == tag2);
  assign miss1 = bus.gfx1_cs && !hit1;
  assign miss2 = bus.gfx2_cs && !hit2;

  assign bus.gfx1_ok    = bus.gfx1_cs && hit1;
  assign bus.gfx2_ok    = bus.gfx2_cs && hit2;
  assign bus.gfx1_data  = word1;
  assign bus.gfx2_data  = word2;
  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    req_addr_nxt = req_addr;
    req_nxt      = req_q;
    addr_nxt     = addr_q;
    fill         = 1'b0;
    case (state)
      IDLE: begin
        if (miss1 || miss2) begin
          // On contention the slot not served last wins
          sel_nxt      = (miss1 && miss2) ? !last2 : miss2;
          req_addr_nxt = sel_nxt ? bus.gfx2_addr : bus.gfx1_addr;
          addr_nxt     = sel_nxt ? GFX2_OFFSET + {4'b0, bus.gfx2_addr}
                                 : GFX1_OFFSET + {4'b0, bus.gfx1_addr};
          req_nxt      = 1'b1;
          state_nxt    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.sdram_ack) begin
          req_nxt = 1'b0;
          if (bus.sdram_rdy) begin
            fill      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (bus.sdram_rdy) begin
          fill      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sel      <= 1'b0;
      last2    <= 1'b1;
      req_addr <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      valid1   <= 1'b0;
      valid2   <= 1'b0;
      tag1     <= '0;
      tag2     <= '0;
      word1    <= '0;
      word2    <= '0;
    end else begin
      sel      <= sel_nxt;
      req_addr <= req_addr_nxt;
      req_q    <= req_nxt;
      addr_q   <= addr_nxt;
      if (fill) begin
        last2 <= sel;
        if (sel) begin
          valid2 <= 1'b1;
          tag2   <= req_addr;
          word2  <= bus.sdram_din;
        end else begin
          valid1 <= 1'b1;
          tag1   <= req_addr;
          word1  <= bus.sdram_din;
        end
      end
    end
  end

`ifdef JTCONTRA_SLOT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn || stat_clr) begin
      stat_miss1 <= '0;
      stat_miss2 <= '0;
    end else if (fill) begin
      if (!sel && stat_miss1 != 16'hFFFF) stat_miss1 <= stat_miss1 + 16'd1;
      if ( sel && stat_miss2 != 16'hFFFF) stat_miss2 <= stat_miss2 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jtcontra_gfx_slot.sv
// Bench for jtcontra_gfx_slot: directed scenarios followed by random traffic, checked every cycle
// against a transaction-level model of the two caches and the pending fetch.
module tb_jtcontra_gfx_slot;

  localparam logic [21:0] OFF1 = 22'h0;
  localparam logic [21:0] OFF2 = 22'h40000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  jtcontra_gfx_slot_if bus ();

`ifdef JTCONTRA_SLOT_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_miss1, stat_miss2;
`endif

  jtcontra_gfx_slot #(.GFX1_OFFSET(OFF1), .GFX2_OFFSET(OFF2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
`ifdef JTCONTRA_SLOT_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_miss1 (stat_miss1),
    .stat_miss2 (stat_miss2)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: per-slot cache contents and the single outstanding fetch
  logic        m_valid [2];
  logic [17:0] m_tag   [2];
  logic [15:0] m_word  [2];
  int          m_last;
  logic        m_busy, m_acked;
  int          m_slot;
  logic [17:0] m_ptag;
  logic [21:0] m_addr;
  int          m_st [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_word[i] = '0; m_st[i] = 0;
    end
    m_last = 1; m_busy = 1'b0; m_acked = 1'b0; m_slot = 0; m_ptag = '0; m_addr = '0;
  endtask

  task automatic model_update();
    logic        cs [2];
    logic [17:0] ad [2];
    logic        miss [2];
    logic        done;
    cs[0] = bus.gfx1_cs; ad[0] = bus.gfx1_addr;
    cs[1] = bus.gfx2_cs; ad[1] = bus.gfx2_addr;
    done = 1'b0;
    if (!rstn) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      for (int i = 0; i < 2; i++) miss[i] = cs[i] && !(m_valid[i] && ad[i] == m_tag[i]);
      if (miss[0] || miss[1]) begin
        if (miss[0] && miss[1]) m_slot = (m_last == 1) ? 0 : 1;
        else                    m_slot = miss[1] ? 1 : 0;
        m_busy  = 1'b1;
        m_acked = 1'b0;
        m_ptag  = ad[m_slot];
        m_addr  = ((m_slot == 1) ? OFF2 : OFF1) + {4'b0, ad[m_slot]};
      end
    end else if (!m_acked) begin
      if (bus.sdram_ack) begin
        m_acked = 1'b1;
        done = bus.sdram_rdy;
      end
    end else begin
      done = bus.sdram_rdy;
    end
    if (done) begin
      m_valid[m_slot] = 1'b1;
      m_tag[m_slot]   = m_ptag;
      m_word[m_slot]  = bus.sdram_din;
      m_last = m_slot;
      m_busy = 1'b0;
    end
`ifdef JTCONTRA_SLOT_STATS_EN
    if (stat_clr) begin
      m_st[0] = 0; m_st[1] = 0;
    end else if (done && m_st[m_slot] < 65535) begin
      m_st[m_slot]++;
    end
`endif
  endtask

  task automatic check_outputs();
    chk("gfx1_ok",   bus.gfx1_ok,
        bus.gfx1_cs && m_valid[0] && bus.gfx1_addr == m_tag[0]);
    chk("gfx2_ok",   bus.gfx2_ok,
        bus.gfx2_cs && m_valid[1] && bus.gfx2_addr == m_tag[1]);
    chk("gfx1_data", bus.gfx1_data, m_word[0]);
    chk("gfx2_data", bus.gfx2_data, m_word[1]);
    chk("sdram_req", bus.sdram_req, m_busy && !m_acked);
    chk("sdram_addr", bus.sdram_addr, m_addr);
`ifdef JTCONTRA_SLOT_STATS_EN
    chk("stat_miss1", stat_miss1, m_st[0]);
    chk("stat_miss2", stat_miss2, m_st[1]);
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, let the DUT clock, then check
  task automatic step(input logic c1, input logic [17:0] a1, input logic c2, input logic [17:0] a2,
                      input logic ack, input logic rdy, input logic [15:0] din);
    bus.gfx1_cs = c1; bus.gfx1_addr = a1;
    bus.gfx2_cs = c2; bus.gfx2_addr = a2;
    bus.sdram_ack = ack; bus.sdram_rdy = rdy; bus.sdram_din = din;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(0, 0, 0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 0, 0, 16'h0);
    rstn = 1'b1;
  endtask

  task automatic fetch1(input logic [17:0] a, input logic [15:0] d);
    step(1, a, 0, 0, 0, 0, 0);
    step(1, a, 0, 0, 1, 0, 0);
    step(1, a, 0, 0, 0, 1, d);
  endtask

  initial begin
    bus.gfx1_cs = 0; bus.gfx1_addr = 0; bus.gfx2_cs = 0; bus.gfx2_addr = 0;
    bus.sdram_ack = 0; bus.sdram_rdy = 0; bus.sdram_din = 0;
    model_reset();
    @(negedge clk);

    do_reset();
    chk("rst_req", bus.sdram_req, 1'b0);
    chk("rst_addr", bus.sdram_addr, 22'h0);
    chk("rst_data1", bus.gfx1_data, 16'h0);
    chk("rst_data2", bus.gfx2_data, 16'h0);

    // Single miss then a same-cycle hit
    step(1, 18'h00123, 0, 0, 0, 0, 0);
    chk("miss_req", bus.sdram_req, 1'b1);
    chk("miss_addr", bus.sdram_addr, 22'h000123);
    step(1, 18'h00123, 0, 0, 1, 0, 0);
    chk("ack_req", bus.sdram_req, 1'b0);
    step(1, 18'h00123, 0, 0, 0, 1, 16'hBEEF);
    chk("fill_ok1", bus.gfx1_ok, 1'b1);
    chk("fill_data1", bus.gfx1_data, 16'hBEEF);
    step(0, 18'h00123, 0, 0, 0, 0, 0);
    step(1, 18'h00123, 0, 0, 0, 0, 0);
    chk("hit_ok1", bus.gfx1_ok, 1'b1);
    chk("hit_req", bus.sdram_req, 1'b0);

    // Contention on the same address: gfx1 first, then gfx2 with its offset
    do_reset();
    step(1, 18'h10, 1, 18'h10, 0, 0, 0);
    chk("cont_addr1", bus.sdram_addr, 22'h000010);
    step(1, 18'h10, 1, 18'h10, 1, 1, 16'h1111);
    step(1, 18'h10, 1, 18'h10, 0, 0, 0);
    chk("cont_addr2", bus.sdram_addr, 22'h040010);
    chk("cont_req2", bus.sdram_req, 1'b1);
    step(1, 18'h10, 1, 18'h10, 1, 0, 0);
    step(1, 18'h10, 1, 18'h10, 0, 1, 16'h2222);
    chk("cont_data1", bus.gfx1_data, 16'h1111);
    chk("cont_data2", bus.gfx2_data, 16'h2222);
    chk("cont_ok2", bus.gfx2_ok, 1'b1);

    // Address change while waiting for data
    do_reset();
    step(0, 0, 1, 18'h5, 0, 0, 0);
    chk("chg_addr", bus.sdram_addr, 22'h040005);
    step(0, 0, 1, 18'h5, 1, 0, 0);
    step(0, 0, 1, 18'h6, 0, 0, 0);
    step(0, 0, 1, 18'h6, 0, 1, 16'h5555);
    chk("chg_ok2", bus.gfx2_ok, 1'b0);
    step(0, 0, 1, 18'h6, 0, 0, 0);
    chk("chg_req", bus.sdram_req, 1'b1);
    chk("chg_addr2", bus.sdram_addr, 22'h040006);
    step(0, 0, 1, 18'h5, 0, 0, 0);
    chk("chg_tag_ok2", bus.gfx2_ok, 1'b1);
    chk("chg_tag_data2", bus.gfx2_data, 16'h5555);

    // Reset during WAIT_RDY, then a stray rdy
    do_reset();
    step(1, 18'h7, 0, 0, 0, 0, 0);
    step(1, 18'h7, 0, 0, 1, 0, 0);
    do_reset();
    step(0, 18'h7, 0, 0, 0, 1, 16'hDEAD);
    chk("rstmid_req", bus.sdram_req, 1'b0);
    chk("rstmid_data1", bus.gfx1_data, 16'h0);
    step(1, 18'h7, 1, 18'h7, 0, 0, 0);
    chk("rstmid_ok1", bus.gfx1_ok, 1'b0);
    chk("rstmid_ok2", bus.gfx2_ok, 1'b0);

`ifdef JTCONTRA_SLOT_STATS_EN
    do_reset();
    fetch1(18'h1, 16'hA001);
    fetch1(18'h2, 16'hA002);
    fetch1(18'h3, 16'hA003);
    step(0, 0, 1, 18'h9, 0, 0, 0);
    step(0, 0, 1, 18'h9, 1, 0, 0);
    step(0, 0, 1, 18'h9, 0, 1, 16'hB009);
    chk("stat1_cnt", stat_miss1, 16'd3);
    chk("stat2_cnt", stat_miss2, 16'd1);
    stat_clr = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    stat_clr = 1'b0;
    chk("stat1_clr", stat_miss1, 16'd0);
    chk("stat2_clr", stat_miss2, 16'd0);
`else
    do_reset();
    fetch1(18'h1, 16'hA001);
    chk("f1_data1", bus.gfx1_data, 16'hA001);
`endif

    // Random traffic over a small address set so hits, contention and stray pulses all occur
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rstn = ($urandom_range(0, 249) != 0);
`ifdef JTCONTRA_SLOT_STATS_EN
      stat_clr = ($urandom_range(0, 99) == 0);
`endif
      step($urandom_range(0, 9) < 7, 18'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 7, 18'($urandom_range(0, 3)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           16'($urandom));
    end
    rstn = 1'b1;
`ifdef JTCONTRA_SLOT_STATS_EN
    stat_clr = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/jtcontra_gfx_slot.md
Name: jtcontra_gfx_slot

Overview:
- Responder side of the graphics ROM fetch interface: serves the `gfxN_cs/gfxN_addr` → `gfxN_data/gfxN_ok` requests issued by the two tile/sprite layer engines.
- Arbitrates both requesters onto a single SDRAM read port.
- Holds a one-word cache per requester, so repeated reads of the same address are answered without an SDRAM access.
- Sits between the video block and the SDRAM controller.

Parameters:
- GFX1_OFFSET, 22'h0, SDRAM word offset added to gfx1 addresses.
- GFX2_OFFSET, 22'h40000, SDRAM word offset added to gfx2 addresses.

Ports:
- clk  in  1  system clock (48 MHz).
- rstn  in  1  synchronous reset, active low.
- gfx1_cs  in  1  gfx1 read request.
- gfx1_addr  in  18  gfx1 word address.
- gfx1_data  out  16  gfx1 read data.
- gfx1_ok  out  1  gfx1 data valid for current address.
- gfx2_cs  in  1  gfx2 read request.
- gfx2_addr  in  18  gfx2 word address.
- gfx2_data  out  16  gfx2 read data.
- gfx2_ok  out  1  gfx2 data valid for current address.
- sdram_req  out  1  SDRAM read request, held until ack.
- sdram_addr  out  22  SDRAM word address.
- sdram_ack  in  1  one-cycle pulse: request accepted.
- sdram_rdy  in  1  one-cycle pulse: sdram_din valid.
- sdram_din  in  16  SDRAM read data.

Behaviour:
- Reset (rstn low at a clk edge):
  - State goes to IDLE; sdram_req=0; sdram_addr=0.
  - Both cache valid bits cleared; cache data=0.
  - gfx1_ok=gfx2_ok=0, gfx1_data=gfx2_data=0.
  - Last-served pointer set to gfx2, so gfx1 wins the first tie.
- Per slot N, the cache holds valid_N, tag_N[17:0] and word_N[15:0].
- gfxN_ok = gfxN_cs & valid_N & (gfxN_addr==tag_N). This is combinational on registered cache state.
- gfxN_data = word_N at all times.
- Miss_N = gfxN_cs & ~(valid_N & gfxN_addr==tag_N).
- IDLE state:
  - If any miss is pending, choose the slot. With only one miss, take that slot. With both, take the slot not last served (round-robin).
  - Latch the chosen slot and its address into req_addr.
  - Set sdram_addr = GFXN_OFFSET + {4'b0, gfxN_addr}. Addition is modulo 2^22 with no overflow flag.
  - Set sdram_req=1 and go to WAIT_ACK.
- WAIT_ACK state: on sdram_ack, set sdram_req=0 and go to WAIT_RDY. sdram_req stays high until ack, with no timeout.
- WAIT_RDY state:
  - On sdram_rdy, write tag_N=req_addr, word_N=sdram_din, valid_N=1.
  - Update the last-served pointer and return to IDLE.
  - gfxN_ok can rise on the next cycle at the earliest. Minimum miss latency from cs to ok is 3 cycles plus the SDRAM latency.
  - A new arbitration can start in the cycle after the return to IDLE.
- Boundary conditions:
  - Address changes during a fetch: the fill still uses the latched req_addr. ok stays low for the new address, and a new miss is arbitrated after the return to IDLE.
  - cs drops during a fetch: the fetch completes and the cache is filled. There is no cancel.
  - sdram_ack and sdram_rdy in the same cycle while in WAIT_ACK: treat it as ack followed by immediate completion, fill the cache and go to IDLE.
  - sdram_rdy outside WAIT_RDY is ignored. sdram_ack outside WAIT_ACK is ignored.
  - The two slots' caches are independent. The same address on both slots fetches twice, once per slot, because the offsets differ.
  - Reset during WAIT_ACK or WAIT_RDY aborts the fetch. A later stray rdy is ignored by the IDLE rule above.

Optional Feature:
- Macro: JTCONTRA_SLOT_STATS_EN.
- Defined:
  - Adds output ports stat_miss1[15:0] and stat_miss2[15:0].
  - Each counts completed fills per slot, saturates at 16'hFFFF, and is cleared by reset.
  - Adds input stat_clr, which zeroes both counters synchronously. stat_clr has priority over an increment in the same cycle.
- Not defined: the ports are absent and no counter logic is synthesised. Functional behaviour is otherwise identical.

Test Plan:
- Single miss: after reset, gfx1_cs=1, gfx1_addr=18'h00123 → sdram_req=1 with sdram_addr=22'h000123. After ack, then rdy with din=16'hBEEF, gfx1_ok=1 and gfx1_data=16'hBEEF on the next cycle.
- Hit: hold gfx1_addr=18'h00123 after the fill, then toggle cs 0→1 → gfx1_ok=1 in the same cycle, and sdram_req stays 0.
- Offset and contention: gfx1 and gfx2 both request address 18'h00010 in the same cycle → first sdram_addr=22'h000010 (gfx1), second sdram_addr=22'h040010 (gfx2). Each slot gets only its own data.
- Address change mid-fetch: change gfx2_addr from 18'h00005 to 18'h00006 during WAIT_RDY → the fill stores tag 18'h00005 and gfx2_ok stays 0. A second request goes out with sdram_addr=22'h040006.
- Reset mid-fetch: assert rstn=0 while in WAIT_RDY, release, then pulse sdram_rdy → no ok asserted, both valid bits stay 0, sdram_req=0.
- Stats (macro defined): perform 3 gfx1 misses and 1 gfx2 miss → stat_miss1=3, stat_miss2=1. Then pulse stat_clr → both counters read 0.
